// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pkg
// Purpose  : Shared video types and constants for the compositor slice.
//            rgb444_t          - 12-bit RGB444 pixel
//            KEY_COLOR_DEFAULT - default transparent colour key
//            layer_e           - compositing layers, lowest priority first
// Revision : 1.0 - initial release
// ============================================================================
package video_pkg;

  typedef logic [11:0] rgb444_t;

  localparam rgb444_t KEY_COLOR_DEFAULT = 12'h000;

  typedef enum logic [2:0] {
    L_BG  = 3'd0,
    L_OBJ = 3'd1,
    L_P1  = 3'd2,
    L_P2  = 3'd3,
    L_UI  = 3'd4
  } layer_e;

endpackage : video_pkg
`default_nettype wire

// File: rtl/pixel_delay.sv
`default_nettype none
// ============================================================================
// Module   : pixel_delay
// Purpose  : Fixed-depth register delay line used to align render latencies.
//            DEPTH = 0 is a plain wire.
// Ports    : clk   - clock
//            rst_n - asynchronous active-low clear of every stage
//            d     - WIDTH-bit input
//            q     - d delayed by DEPTH clocks
// Revision : 1.0 - initial release
// ============================================================================
module pixel_delay #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock and clear are not needed by a zero-depth line.
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clk & rst_n;
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] r_stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
          end
        end else begin
          r_stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule : pixel_delay
`default_nettype wire

// File: rtl/pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module   : pixel_compositor
// Purpose  : Aligns the bg/obj/p1/p2/ui render streams to a common depth,
//            merges them by fixed priority with colour-key transparency,
//            and drives registered RGB444 plus matching syncs to the VGA port.
//            A frame counter (ticked on aligned vsync rise) blinks the UI.
// Ports    : pixel_clk_in, rst_n_in        - clock, async active-low reset
//            hsync_in/vsync_in/blank_in    - timing, latency 0
//            bg/obj/p1/p2/ui_pixel_in      - layer pixels at their latencies
//            blink_en_in                   - UI blink enable, taken at frame tick
//            pixel_out, hsync_out, vsync_out, blank_out - composited output
//            frame_count_out               - frames since reset (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module pixel_compositor
  import video_pkg::*;
#(
  parameter int      ALIGN_DEPTH = 3,
  parameter int      BG_LAT      = 3,
  parameter int      OBJ_LAT     = 2,
  parameter int      P1_LAT      = 2,
  parameter int      P2_LAT      = 2,
  parameter int      UI_LAT      = 1,
  parameter rgb444_t KEY_COLOR   = KEY_COLOR_DEFAULT,
  parameter int      BLINK_BIT   = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [11:0] bg_pixel_in,
  input  logic [11:0] obj_pixel_in,
  input  logic [11:0] p1_pixel_in,
  input  logic [11:0] p2_pixel_in,
  input  logic [11:0] ui_pixel_in,
  input  logic        blink_en_in,
  output logic [11:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic [7:0]  frame_count_out
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (BG_LAT > ALIGN_DEPTH) begin : g_chk_bg
      $fatal(1, "pixel_compositor: BG_LAT exceeds ALIGN_DEPTH");
    end
    if (OBJ_LAT > ALIGN_DEPTH) begin : g_chk_obj
      $fatal(1, "pixel_compositor: OBJ_LAT exceeds ALIGN_DEPTH");
    end
    if (P1_LAT > ALIGN_DEPTH) begin : g_chk_p1
      $fatal(1, "pixel_compositor: P1_LAT exceeds ALIGN_DEPTH");
    end
    if (P2_LAT > ALIGN_DEPTH) begin : g_chk_p2
      $fatal(1, "pixel_compositor: P2_LAT exceeds ALIGN_DEPTH");
    end
    if (UI_LAT > ALIGN_DEPTH) begin : g_chk_ui
      $fatal(1, "pixel_compositor: UI_LAT exceeds ALIGN_DEPTH");
    end
    if (BLINK_BIT > 7) begin : g_chk_blink
      $fatal(1, "pixel_compositor: BLINK_BIT outside 8-bit frame counter");
    end
  endgenerate

  localparam int c_bg_dly  = ALIGN_DEPTH - BG_LAT;
  localparam int c_obj_dly = ALIGN_DEPTH - OBJ_LAT;
  localparam int c_p1_dly  = ALIGN_DEPTH - P1_LAT;
  localparam int c_p2_dly  = ALIGN_DEPTH - P2_LAT;
  localparam int c_ui_dly  = ALIGN_DEPTH - UI_LAT;

  // --------------------------------------------------------------------------
  // Latency alignment
  // --------------------------------------------------------------------------
  rgb444_t    w_bg_a, w_obj_a, w_p1_a, w_p2_a, w_ui_a;
  logic [2:0] w_sync_a;   // {hsync, vsync, blank} at the mux stage
  logic       w_hs_a, w_vs_a, w_blank_a;

  pixel_delay #(.WIDTH(12), .DEPTH(c_bg_dly)) u_dly_bg (
    .clk(pixel_clk_in), .rst_n(rst_n_in), .d(bg_pixel_in),  .q(w_bg_a)
  );
  pixel_delay #(.WIDTH(12), .DEPTH(c_obj_dly)) u_dly_obj (
    .clk(pixel_clk_in), .rst_n(rst_n_in), .d(obj_pixel_in), .q(w_obj_a)
  );
  pixel_delay #(.WIDTH(12), .DEPTH(c_p1_dly)) u_dly_p1 (
    .clk(pixel_clk_in), .rst_n(rst_n_in), .d(p1_pixel_in),  .q(w_p1_a)
  );
  pixel_delay #(.WIDTH(12), .DEPTH(c_p2_dly)) u_dly_p2 (
    .clk(pixel_clk_in), .rst_n(rst_n_in), .d(p2_pixel_in),  .q(w_p2_a)
  );
  pixel_delay #(.WIDTH(12), .DEPTH(c_ui_dly)) u_dly_ui (
    .clk(pixel_clk_in), .rst_n(rst_n_in), .d(ui_pixel_in),  .q(w_ui_a)
  );
  pixel_delay #(.WIDTH(3), .DEPTH(ALIGN_DEPTH)) u_dly_sync (
    .clk(pixel_clk_in), .rst_n(rst_n_in),
    .d({hsync_in, vsync_in, blank_in}), .q(w_sync_a)
  );

  assign w_hs_a    = w_sync_a[2];
  assign w_vs_a    = w_sync_a[1];
  assign w_blank_a = w_sync_a[0];

  // --------------------------------------------------------------------------
  // Frame tick, counter and blink enable
  // --------------------------------------------------------------------------
  logic       r_vs_prev;
  logic [7:0] r_frame_count;
  logic       r_blink_en_q;
  logic       w_tick;
  logic       w_ui_visible;

  assign w_tick = w_vs_a & ~r_vs_prev;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_vs_prev     <= 1'b0;
      r_frame_count <= 8'd0;
      r_blink_en_q  <= 1'b0;
    end else begin
      r_vs_prev <= w_vs_a;
      if (w_tick) begin
        r_frame_count <= r_frame_count + 8'd1;
        // Captured only at the tick so the UI state is stable for a frame.
        r_blink_en_q  <= blink_en_in;
      end
    end
  end

  assign w_ui_visible = !r_blink_en_q || !r_frame_count[BLINK_BIT];

  // --------------------------------------------------------------------------
  // Priority select and output register
  // --------------------------------------------------------------------------
  layer_e  w_sel;
  rgb444_t w_pixel;

  always_comb begin
    w_sel = L_BG;
    if (w_ui_visible && (w_ui_a != KEY_COLOR)) begin
      w_sel = L_UI;
    end else if (w_p2_a != KEY_COLOR) begin
      w_sel = L_P2;
    end else if (w_p1_a != KEY_COLOR) begin
      w_sel = L_P1;
    end else if (w_obj_a != KEY_COLOR) begin
      w_sel = L_OBJ;
    end
  end

  always_comb begin
    w_pixel = w_bg_a;   // bg is the fallback even when it equals the key
    case (w_sel)
      L_UI:    w_pixel = w_ui_a;
      L_P2:    w_pixel = w_p2_a;
      L_P1:    w_pixel = w_p1_a;
      L_OBJ:   w_pixel = w_obj_a;
      default: w_pixel = w_bg_a;
    endcase
    if (w_blank_a) begin
      w_pixel = 12'h000;
    end
  end

  logic [11:0] r_pixel;
  logic        r_hsync, r_vsync, r_blank;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_pixel <= 12'h000;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_blank <= 1'b0;
    end else begin
      r_pixel <= w_pixel;
      r_hsync <= w_hs_a;
      r_vsync <= w_vs_a;
      r_blank <= w_blank_a;
    end
  end

  assign pixel_out       = r_pixel;
  assign hsync_out       = r_hsync;
  assign vsync_out       = r_vsync;
  assign blank_out       = r_blank;
  assign frame_count_out = r_frame_count;

endmodule : pixel_compositor
`default_nettype wire

// File: tb/tb_pixel_compositor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_compositor
// Purpose  : Self-checking bench for pixel_compositor. Layer sources are
//            generated at coordinate time and passed through renderer
//            latency models (bg 3, obj/p1/p2 2, ui 1) before the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_compositor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync, vsync, blank, blink_en;
  logic [11:0] bg_src, obj_src, p1_src, p2_src, ui_src;
  logic [11:0] bg_p [3];
  logic [11:0] obj_p [2];
  logic [11:0] p1_p [2];
  logic [11:0] p2_p [2];
  logic [11:0] ui_p;
  logic [11:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out;
  logic [7:0]  frame_count_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Renderer latency models
  always @(posedge clk) begin
    bg_p[0]  <= bg_src;  bg_p[1]  <= bg_p[0];  bg_p[2] <= bg_p[1];
    obj_p[0] <= obj_src; obj_p[1] <= obj_p[0];
    p1_p[0]  <= p1_src;  p1_p[1]  <= p1_p[0];
    p2_p[0]  <= p2_src;  p2_p[1]  <= p2_p[0];
    ui_p     <= ui_src;
  end

  pixel_compositor dut (
    .pixel_clk_in    (clk),
    .rst_n_in        (rst_n),
    .hsync_in        (hsync),
    .vsync_in        (vsync),
    .blank_in        (blank),
    .bg_pixel_in     (bg_p[2]),
    .obj_pixel_in    (obj_p[1]),
    .p1_pixel_in     (p1_p[1]),
    .p2_pixel_in     (p2_p[1]),
    .ui_pixel_in     (ui_p),
    .blink_en_in     (blink_en),
    .pixel_out       (pixel_out),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .blank_out       (blank_out),
    .frame_count_out (frame_count_out)
  );

  typedef struct {
    logic [11:0] bg, obj, p1, p2, ui;
    logic        blank;
    logic [11:0] exp_pixel;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_layers(input logic [11:0] b, o, a, c, u);
    bg_src = b; obj_src = o; p1_src = a; p2_src = c; ui_src = u;
  endtask

  // Reset asserted at a negedge, released on the next one.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One vsync pulse followed by enough idle cycles to reach the output.
  task automatic vs_pulse();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    wait_n(6);
  endtask

  // Back-to-back pulses: one tick every two cycles.
  task automatic vs_burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); vsync = 1'b1;
      @(negedge clk); vsync = 1'b0;
    end
    wait_n(6);
  endtask

  initial begin
    vecs[0] = '{bg:12'h971, obj:12'h0A0, p1:12'hF00, p2:12'h00F, ui:12'hFFF, blank:1'b0, exp_pixel:12'hFFF};
    vecs[1] = '{bg:12'h971, obj:12'h0A0, p1:12'hF00, p2:12'h00F, ui:12'h000, blank:1'b0, exp_pixel:12'h00F};
    vecs[2] = '{bg:12'h971, obj:12'h0A0, p1:12'hF00, p2:12'h000, ui:12'h000, blank:1'b0, exp_pixel:12'hF00};
    vecs[3] = '{bg:12'h971, obj:12'h0A0, p1:12'h000, p2:12'h000, ui:12'h000, blank:1'b0, exp_pixel:12'h0A0};
    vecs[4] = '{bg:12'h971, obj:12'h000, p1:12'h000, p2:12'h000, ui:12'h000, blank:1'b0, exp_pixel:12'h971};
    vecs[5] = '{bg:12'h000, obj:12'h000, p1:12'h000, p2:12'h000, ui:12'h000, blank:1'b0, exp_pixel:12'h000};
    vecs[6] = '{bg:12'h971, obj:12'h0A0, p1:12'h000, p2:12'h00F, ui:12'h000, blank:1'b0, exp_pixel:12'h00F};
    vecs[7] = '{bg:12'h971, obj:12'h0A0, p1:12'hF00, p2:12'h00F, ui:12'hFFF, blank:1'b1, exp_pixel:12'h000};
    vecs[8] = '{bg:12'h000, obj:12'h000, p1:12'h000, p2:12'h000, ui:12'h123, blank:1'b0, exp_pixel:12'h123};

    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; blank = 1'b0; blink_en = 1'b0;
    set_layers(12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
    wait_n(5);

    // Reset state
    chk("rst_pixel", {20'd0, pixel_out}, 32'h0);
    chk("rst_syncs", {29'd0, hsync_out, vsync_out, blank_out}, 32'h0);
    chk("rst_count", {24'd0, frame_count_out}, 32'h0);

    // First post-reset input emerges exactly 4 cycles later
    @(negedge clk);
    rst_n = 1'b1;
    bg_src = 12'hB70;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("first_pix_c%0d", k), {20'd0, pixel_out}, (k < 4) ? 32'h000 : 32'hB70);
    end

    // Alignment: x drives bg (lat 3), p1 (lat 2) and hsync (lat 0)
    for (int i = 0; i < 25; i++) begin
      logic [11:0] x;
      logic [11:0] xe;
      @(negedge clk);
      if (i >= 4) begin
        xe = 12'd190 + 12'(i - 4);
        chk($sformatf("align_pix_x%0d", xe), {20'd0, pixel_out},
            (xe == 12'd200) ? 32'hF00 : {20'd0, 4'h3, xe[7:0]});
        chk($sformatf("align_hs_x%0d", xe), {31'd0, hsync_out}, {31'd0, xe == 12'd205});
      end
      x = 12'd190 + 12'(i);
      bg_src = {4'h3, x[7:0]};
      p1_src = (x == 12'd200) ? 12'hF00 : 12'h000;
      hsync  = (x == 12'd205);
    end
    hsync = 1'b0;
    p1_src = 12'h000;

    // Priority / blank table
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      set_layers(vecs[v].bg, vecs[v].obj, vecs[v].p1, vecs[v].p2, vecs[v].ui);
      blank = vecs[v].blank;
      wait_n(5);
      chk($sformatf("prio_v%0d_pix", v), {20'd0, pixel_out}, {20'd0, vecs[v].exp_pixel});
      chk($sformatf("prio_v%0d_blank", v), {31'd0, blank_out}, {31'd0, vecs[v].blank});
    end

    // Blank override timing: both pixel and blank_out flip on cycle 4
    @(negedge clk);
    set_layers(12'h971, 12'h0A0, 12'hF00, 12'h00F, 12'hFFF);
    blank = 1'b0;
    wait_n(5);
    @(negedge clk);
    blank = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("blank_pix_c%0d", k), {20'd0, pixel_out}, (k < 4) ? 32'hFFF : 32'h000);
      chk($sformatf("blank_out_c%0d", k), {31'd0, blank_out}, (k < 4) ? 32'h0 : 32'h1);
    end
    blank = 1'b0;

    // Blink over 32+ frames
    do_reset();
    set_layers(12'hB70, 12'h000, 12'h000, 12'h000, 12'hFFF);
    blink_en = 1'b1;
    wait_n(6);
    chk("blink_f0_pix", {20'd0, pixel_out}, 32'hFFF);
    // First tick: count and vsync_out move together on cycle 4
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("tick_cnt_c%0d", k), {24'd0, frame_count_out}, (k < 4) ? 32'd0 : 32'd1);
      chk($sformatf("tick_vs_c%0d", k), {31'd0, vsync_out}, (k < 4) ? 32'd0 : 32'd1);
    end
    wait_n(4);
    for (int f = 2; f <= 32; f++) begin
      vs_pulse();
      if (f == 15 || f == 16 || f == 31 || f == 32) begin
        chk($sformatf("blink_f%0d_cnt", f), {24'd0, frame_count_out}, 32'(f));
        chk($sformatf("blink_f%0d_pix", f), {20'd0, pixel_out}, (f[4]) ? 32'hB70 : 32'hFFF);
      end
    end
    vs_burst(16);
    chk("blink_f48_pix", {20'd0, pixel_out}, 32'hB70);
    // Mid-frame change of blink_en has no effect until the next tick
    blink_en = 1'b0;
    wait_n(8);
    chk("blink_midframe_pix", {20'd0, pixel_out}, 32'hB70);
    vs_pulse();
    chk("blink_f49_cnt", {24'd0, frame_count_out}, 32'd49);
    chk("blink_f49_pix", {20'd0, pixel_out}, 32'hFFF);

    // Count to 255, then asynchronous reset mid-cycle
    do_reset();
    set_layers(12'hB70, 12'h000, 12'h000, 12'h000, 12'h000);
    vs_burst(255);
    chk("cnt_255", {24'd0, frame_count_out}, 32'd255);
    chk("pre_areset_pix", {20'd0, pixel_out}, 32'hB70);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_pix", {20'd0, pixel_out}, 32'h0);
    chk("areset_cnt", {24'd0, frame_count_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(8);
    chk("post_rst_no_tick", {24'd0, frame_count_out}, 32'd0);
    vs_pulse();
    chk("post_rst_cnt1", {24'd0, frame_count_out}, 32'd1);

    // Wrap without reset
    do_reset();
    vs_burst(255);
    chk("wrap_pre", {24'd0, frame_count_out}, 32'd255);
    vs_pulse();
    chk("wrap_zero", {24'd0, frame_count_out}, 32'd0);
    vs_pulse();
    chk("wrap_one", {24'd0, frame_count_out}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pixel_compositor
`default_nettype wire

// File: doc/pixel_compositor.md
Name: pixel_compositor

Overview:
- Downstream stage of the background/table/sprite renderers. Merges their 12-bit RGB pixel streams by fixed layer priority, with colour-key transparency.
- Aligns each layer's render latency to a common depth, delays hsync/vsync/blank to match, and drives a registered pixel plus syncs to the VGA output.
- Keeps a frame counter used to blink the UI layer (e.g. order timers, highlighted counters).

Parameters:
- ALIGN_DEPTH, 3: common pipeline depth. Every layer's latency must be ≤ this value.
- BG_LAT, 3: cycles from hcount/vcount to bg_pixel_in (address register, palette ROM, output register).
- OBJ_LAT, 2: latency of obj_pixel_in (table-top items).
- P1_LAT, 2: latency of p1_pixel_in.
- P2_LAT, 2: latency of p2_pixel_in.
- UI_LAT, 1: latency of ui_pixel_in.
- KEY_COLOR, 12'h000: transparent colour key for every layer except bg.
- BLINK_BIT, 4: frame-counter bit gating the UI blink (toggles every 16 frames).

Ports:
- pixel_clk_in  in  1  pixel clock; the single clock of the block.
- rst_n_in  in  1  reset; asynchronous assert, active-low.
- hsync_in  in  1  active-high, aligned to hcount/vcount (latency 0).
- vsync_in  in  1  active-high, latency 0.
- blank_in  in  1  active-high, latency 0.
- bg_pixel_in  in  12  background layer (always opaque).
- obj_pixel_in  in  12  object layer.
- p1_pixel_in  in  12  player 1 sprite.
- p2_pixel_in  in  12  player 2 sprite.
- ui_pixel_in  in  12  UI overlay.
- blink_en_in  in  1  enables UI blinking; sampled at frame start.
- pixel_out  out  12  composited RGB444.
- hsync_out  out  1  delayed hsync.
- vsync_out  out  1  delayed vsync.
- blank_out  out  1  delayed blank.
- frame_count_out  out  8  frames since reset.

Behaviour:
- Reset (async, rst_n_in=0): all outputs 0. Clears all delay registers, frame counter, the registered blink enable and the previous-vsync flag.
- Release: synchronous to the next pixel_clk_in edge.
- Layer alignment: layer X is delayed by ALIGN_DEPTH-X_LAT registers. A delay of 0 is a wire.
- Syncs and blank pass through ALIGN_DEPTH registers.
- Mux stage: one registered stage.
  - Total latency: sync/blank input to output = ALIGN_DEPTH+1 cycles (4 by default).
  - For a pixel whose coordinates were presented at cycle t, pixel_out is valid at t+ALIGN_DEPTH+1, in the same cycle as its syncs.
- Priority, highest first: ui (if visible), p2, p1, obj, bg.
  - A layer is opaque when its aligned value != KEY_COLOR.
  - The first opaque layer wins; otherwise bg is used, including when bg equals KEY_COLOR.
- Blank: when aligned blank is 1, pixel_out is 12'h000 regardless of layers.
- Frame tick: aligned vsync rising edge (prev 0, current 1).
  - On a tick, frame_count increments and wraps 255->0.
  - On the same tick, blink_en_in is captured into blink_en_q.
  - frame_count_out updates in the cycle after the edge is registered, along with vsync_out.
- UI visible = !blink_en_q || !frame_count[BLINK_BIT].
  - blink_en_q changes only at a frame tick, so the UI never tears mid-frame.
- Simultaneous opaque layers: priority only, no blending.
- Reset mid-frame: outputs drop to 0 immediately.
  - After release, pixel/sync outputs carry zeros until ALIGN_DEPTH+1 valid inputs have propagated.
  - No spurious frame tick, because the prev-vsync flag resets to 0 and the aligned vsync resets to 0.
- Elaboration check: any X_LAT > ALIGN_DEPTH is a fatal error.

Decomposition:
- Shared package video_pkg:
  - typedef rgb444_t (logic [11:0]).
  - constant KEY_COLOR_DEFAULT = 12'h000.
  - layer enum {L_BG, L_OBJ, L_P1, L_P2, L_UI} for priority and debug.
- Sub-module pixel_delay (params WIDTH, DEPTH; DEPTH=0 is a pass-through).
  - Async active-low clear.
  - Instantiated per layer and once for the {hsync, vsync, blank} bundle.

Test Plan:
- Reset then constant inputs (bg=12'hB70, others=000, blank=0) -> pixel_out=12'hB70 exactly 4 cycles after the first post-reset input; 12'h000 before that.
- Latency alignment: drive bg via a model with latency 3 and p1 with latency 2, placing p1=12'hF00 only at pixel (x=200) -> pixel_out=12'hF00 in the same cycle the aligned hcount 200 emerges; neighbouring pixels show bg.
- Priority: bg=971, obj=0A0, p1=F00, p2=00F, ui=FFF all opaque -> FFF. Then ui=000 -> 00F; p2=000 -> F00; p1=000 -> 0A0.
- Blank override: blank_in=1 with all layers opaque -> pixel_out=000 and blank_out=1, both 4 cycles later.
- Blink: blink_en_in=1, ui=FFF over bg, run 32 vsync pulses -> ui visible for frames 0-15, hidden for 16-31 (bg shown); frame_count_out=32. Toggle blink_en_in mid-frame -> no change until the next vsync rising edge.
- Async reset mid-frame with frame_count=255 -> outputs and count go to 0 without a clock edge. The next vsync rising edge gives count=1; a separate run with no reset shows the 255->0 wrap.
